// File: rtl/rv32_pkg.sv
// RV32I decode definitions shared by the ID stage: opcodes, control bundle and selectors.
package rv32_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic [2:0] funct3;
    } id_ctrl_t;

    // alt selects SUB/SRA; callers decide when instr[30] is meaningful
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational read ports, one clocked write port.
// x0 reads as zero and ignores writes; contents are deliberately not reset.
module decode_stage_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem_q [NUM_REGS];

    // Write port
    always_ff @(posedge clk) begin
        if (we && (waddr != {AW{1'b0}})) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read ports with x0 forced to zero
    always_comb begin
        rdata1 = (raddr1 == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_q[raddr1];
        rdata2 = (raddr2 == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_q[raddr2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes fetch's instruction into a registered ID/EX word with stall/flush.
// Optional: define DECODE_WB_BYPASS_EN to forward same-edge writeback data into the operands.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output id_ctrl_t        id_ctrl,
    output logic            id_illegal
);

    logic [6:0]      opcode_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic            legal_s, bubble_s;
    imm_sel_e        imm_sel_s;
    id_ctrl_t        ctrl_raw_s;
    logic [XLEN-1:0] imm_s, rf_rdata1_s, rf_rdata2_s, rs1_data_s, rs2_data_s;

    logic            valid_d, valid_q, illegal_d, illegal_q;
    logic [XLEN-1:0] pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
    logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    id_ctrl_t        ctrl_d, ctrl_q;

    assign opcode_s = instr_in[6:0];
    assign rd_s     = instr_in[11:7];
    assign rs1_s    = instr_in[19:15];
    assign rs2_s    = instr_in[24:20];
    assign bubble_s = (instr_in == 32'h0000_0000);

    decode_stage_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk    (clk),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .rdata1 (rf_rdata1_s),
        .rdata2 (rf_rdata2_s)
    );

`ifdef DECODE_WB_BYPASS_EN
    // Write-through: a same-edge writeback to a source register wins over the stale read
    always_comb begin
        rs1_data_s = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_s)) ? wb_data : rf_rdata1_s;
        rs2_data_s = (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_s)) ? wb_data : rf_rdata2_s;
    end
`else
    // Operands capture the pre-writeback register file value
    always_comb begin
        rs1_data_s = rf_rdata1_s;
        rs2_data_s = rf_rdata2_s;
    end
`endif

    // Control decode and immediate format selection
    always_comb begin
        ctrl_raw_s = '0;
        imm_sel_s  = IMM_NONE;
        legal_s    = 1'b1;
        case (opcode_s)
            OP: begin
                ctrl_raw_s.reg_wr = 1'b1;
                ctrl_raw_s.alu_op = alu_from_funct3(instr_in[14:12], instr_in[30]);
            end
            OP_IMM: begin
                imm_sel_s              = IMM_I;
                ctrl_raw_s.reg_wr      = 1'b1;
                ctrl_raw_s.alu_src_imm = 1'b1;
                ctrl_raw_s.alu_op      = alu_from_funct3(instr_in[14:12],
                                             (instr_in[14:12] == 3'd5) && instr_in[30]);
            end
            LOAD: begin
                imm_sel_s              = IMM_I;
                ctrl_raw_s.reg_wr      = 1'b1;
                ctrl_raw_s.alu_src_imm = 1'b1;
                ctrl_raw_s.mem_rd      = 1'b1;
            end
            STORE: begin
                imm_sel_s              = IMM_S;
                ctrl_raw_s.alu_src_imm = 1'b1;
                ctrl_raw_s.mem_wr      = 1'b1;
            end
            BRANCH: begin
                imm_sel_s         = IMM_B;
                ctrl_raw_s.branch = 1'b1;
                ctrl_raw_s.alu_op = ALU_SUB;
            end
            JAL: begin
                imm_sel_s         = IMM_J;
                ctrl_raw_s.reg_wr = 1'b1;
                ctrl_raw_s.jal    = 1'b1;
            end
            JALR: begin
                imm_sel_s              = IMM_I;
                ctrl_raw_s.reg_wr      = 1'b1;
                ctrl_raw_s.alu_src_imm = 1'b1;
                ctrl_raw_s.jalr        = 1'b1;
            end
            LUI: begin
                imm_sel_s              = IMM_U;
                ctrl_raw_s.reg_wr      = 1'b1;
                ctrl_raw_s.alu_src_imm = 1'b1;
                ctrl_raw_s.lui         = 1'b1;
            end
            AUIPC: begin
                imm_sel_s              = IMM_U;
                ctrl_raw_s.reg_wr      = 1'b1;
                ctrl_raw_s.alu_src_imm = 1'b1;
                ctrl_raw_s.auipc       = 1'b1;
            end
            SYSTEM, MISC_MEM: begin
                imm_sel_s = IMM_NONE;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        legal_s           = legal_s && (instr_in[1:0] == 2'b11);
        ctrl_raw_s.funct3 = instr_in[14:12];
        ctrl_raw_s.reg_wr = ctrl_raw_s.reg_wr && (rd_s != 5'd0);
    end

    // Sign-extended immediate assembly
    always_comb begin
        case (imm_sel_s)
            IMM_I:   imm_s = {{20{instr_in[31]}}, instr_in[31:20]};
            IMM_S:   imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            IMM_B:   imm_s = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                              instr_in[11:8], 1'b0};
            IMM_U:   imm_s = {instr_in[31:12], 12'h000};
            IMM_J:   imm_s = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                              instr_in[30:21], 1'b0};
            default: imm_s = 32'h0000_0000;
        endcase
    end

    // ID/EX next word: flush clears the side-effecting fields, stall holds everything
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        illegal_d  = illegal_q;
        if (flush) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            illegal_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d    = !bubble_s;
            illegal_d  = !bubble_s && !legal_s;
            ctrl_d     = (bubble_s || !legal_s) ? '0 : ctrl_raw_s;
            pc_d       = pc_in;
            rs1_data_d = rs1_data_s;
            rs2_data_d = rs2_data_s;
            imm_d      = imm_s;
            rs1_d      = rs1_s;
            rs2_d      = rs2_s;
            rd_d       = rd_s;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            pc_q       <= {XLEN{1'b0}};
            rs1_data_q <= {XLEN{1'b0}};
            rs2_data_q <= {XLEN{1'b0}};
            imm_q      <= {XLEN{1'b0}};
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign id_valid    = valid_q;
    assign id_pc       = pc_q;
    assign id_rs1_data = rs1_data_q;
    assign id_rs2_data = rs2_data_q;
    assign id_imm      = imm_q;
    assign id_rs1      = rs1_q;
    assign id_rs2      = rs2_q;
    assign id_rd       = rd_q;
    assign id_ctrl     = ctrl_q;
    assign id_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, multi-cycle corner sequences and
// randomized traffic compared against an ISA-level reference model.
module tb_decode_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, wb_en;
    logic [31:0] instr_in, pc_in, wb_data;
    logic [4:0]  wb_rd;
    logic        id_valid, id_illegal;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    id_ctrl_t    id_ctrl;

    decode_stage dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_ctrl(id_ctrl), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        id_ctrl_t    ctrl;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic        valid;
        logic        illegal;
    } vec_t;

    localparam int K_BAD = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_JAL = 6,
                   K_JR = 7, K_LUI = 8, K_AUI = 9, K_SYS = 10;

    exp_t        exp_q;
    logic        flushed;
    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs [13];
    logic [31:0] want_t3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    function automatic logic [31:0] read_reg(input logic [4:0] r);
        logic [31:0] v;
        v = (r == 5'd0) ? 32'h0 : regs[r];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == r)) v = wb_data;
`endif
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t             e;
        int               kind, imm;
        logic [2:0]       f3;
        logic signed [31:0] s;
        alu_op_e          tab [8];
        tab  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f3   = ins[14:12];
        s    = ins;
        e    = '0;
        e.pc = pc;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.rs1d = read_reg(e.rs1);
        e.rs2d = read_reg(e.rs2);
        case (ins[6:0])
            7'h33: kind = K_R;    7'h13: kind = K_I;   7'h03: kind = K_LD;
            7'h23: kind = K_ST;   7'h63: kind = K_BR;  7'h6F: kind = K_JAL;
            7'h67: kind = K_JR;   7'h37: kind = K_LUI; 7'h17: kind = K_AUI;
            7'h73: kind = K_SYS;  7'h0F: kind = K_SYS;
            default: kind = K_BAD;
        endcase
        case (kind)
            K_I, K_LD, K_JR: imm = s >>> 20;
            K_ST:  imm = (int'(s >>> 25) * 32) + int'(ins[11:7]);
            K_BR:  imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                         + int'(ins[11:8]) * 2;
            K_LUI, K_AUI: imm = int'(ins & 32'hFFFF_F000);
            K_JAL: imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                         + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: imm = 0;
        endcase
        e.imm = 32'(imm);
        if (ins == 32'h0) begin
            e.valid = 1'b0;
        end else if (kind == K_BAD) begin
            e.valid   = 1'b1;
            e.illegal = 1'b1;
        end else begin
            e.valid              = 1'b1;
            e.ctrl.funct3        = f3;
            e.ctrl.reg_wr        = (kind inside {K_R, K_I, K_LD, K_JAL, K_JR, K_LUI, K_AUI})
                                   && (e.rd != 5'd0);
            e.ctrl.alu_src_imm   = kind inside {K_I, K_LD, K_ST, K_JR, K_LUI, K_AUI};
            e.ctrl.mem_rd        = (kind == K_LD);
            e.ctrl.mem_wr        = (kind == K_ST);
            e.ctrl.branch        = (kind == K_BR);
            e.ctrl.jal           = (kind == K_JAL);
            e.ctrl.jalr          = (kind == K_JR);
            e.ctrl.lui           = (kind == K_LUI);
            e.ctrl.auipc         = (kind == K_AUI);
            e.ctrl.alu_op        = ALU_ADD;
            if (kind == K_R || kind == K_I) begin
                e.ctrl.alu_op = tab[f3];
                if (kind == K_R && f3 == 3'd0 && ins[30]) e.ctrl.alu_op = ALU_SUB;
                if (f3 == 3'd5 && ins[30]) e.ctrl.alu_op = ALU_SRA;
            end
            if (kind == K_BR) e.ctrl.alu_op = ALU_SUB;
        end
        return e;
    endfunction

    task automatic check_all();
        chk("valid", 32'(id_valid), 32'(exp_q.valid));
        chk("ctrl", 32'(id_ctrl), 32'(exp_q.ctrl));
        chk("illegal", 32'(id_illegal), 32'(exp_q.illegal));
        if (!flushed) begin
            chk("pc", id_pc, exp_q.pc);
            chk("rs1_data", id_rs1_data, exp_q.rs1d);
            chk("rs2_data", id_rs2_data, exp_q.rs2d);
            chk("imm", id_imm, exp_q.imm);
            chk("rs1", 32'(id_rs1), 32'(exp_q.rs1));
            chk("rs2", 32'(id_rs2), 32'(exp_q.rs2));
            chk("rd", 32'(id_rd), 32'(exp_q.rd));
        end
    endtask

    // Advance one clock: update the model from the inputs at the edge, then compare
    task automatic step();
        if (flush) begin
            exp_q.valid   = 1'b0;
            exp_q.ctrl    = '0;
            exp_q.illegal = 1'b0;
            flushed       = 1'b1;
        end else if (!stall) begin
            exp_q   = model(instr_in, pc_in);
            flushed = 1'b0;
        end
        if (wb_en && (wb_rd != 5'd0)) regs[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11];
        logic [31:0] r;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return r;
            default: return {r[31:7], opcs[$urandom_range(0, 10)]};
        endcase
    endfunction

    initial begin
        vecs[0]  = '{32'hFE000EE3, 32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[1]  = '{32'h800000EF, 32'hFFF00000, 1'b1, 1'b0};
        vecs[2]  = '{32'h00028313, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{32'hFFF12083, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{32'hFE112E23, 32'hFFFFFFFC, 1'b1, 1'b0};
        vecs[5]  = '{32'h123451B7, 32'h12345000, 1'b1, 1'b0};
        vecs[6]  = '{32'h00001197, 32'h00001000, 1'b1, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1};
        vecs[8]  = '{32'h00000012, 32'h00000000, 1'b1, 1'b1};
        vecs[9]  = '{32'h00000073, 32'h00000000, 1'b1, 1'b0};
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[11] = '{32'h0000000F, 32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{32'h008100E7, 32'h00000008, 1'b1, 1'b0};
`ifdef DECODE_WB_BYPASS_EN
        want_t3 = 32'h0000_1234;
`else
        want_t3 = 32'h0000_5555;
`endif

        reset = 1'b0; stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0;
        wb_data = 32'h0; instr_in = 32'h0; pc_in = 32'h0;
        exp_q = '0; flushed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        for (int r = 1; r < 32; r++) begin
            wb_en = 1'b1; wb_rd = 5'(r); wb_data = $urandom;
            step();
        end

        // addi x6,x5,0 after writing x5
        wb_rd = 5'd5; wb_data = 32'hDEADBEEF; instr_in = 32'h0;
        step();
        wb_en = 1'b0; instr_in = 32'h00028313; pc_in = 32'h0000_0200;
        step();
        chk("t2_rs1_data", id_rs1_data, 32'hDEADBEEF);
        chk("t2_imm", id_imm, 32'h0);
        chk("t2_reg_wr", 32'(id_ctrl.reg_wr), 32'h1);
        chk("t2_rd", 32'(id_rd), 32'h6);

        // same-edge writeback of x7 while decoding addi x8,x7,0
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h5555; instr_in = 32'h0;
        step();
        wb_data = 32'h1234; instr_in = 32'h00038413;
        step();
        chk("t3_rs1_data", id_rs1_data, want_t3);
        wb_en = 1'b0;

        // stall holds, flush beats stall
        instr_in = 32'h123451B7; pc_in = 32'h0000_0300;
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_in = $urandom; pc_in = $urandom;
            step();
            chk("t4_hold_pc", id_pc, 32'h0000_0300);
            chk("t4_hold_imm", id_imm, 32'h12345000);
        end
        flush = 1'b1;
        step();
        chk("t4_flush_valid", 32'(id_valid), 32'h0);
        flush = 1'b0; stall = 1'b0;

        // x0 write dropped, also for a same-edge read
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; instr_in = 32'h00000093;
        step();
        chk("t6_x0_same", id_rs1_data, 32'h0);
        wb_en = 1'b0;
        step();
        chk("t6_x0_read", id_rs1_data, 32'h0);

        for (int i = 0; i < 13; i++) begin
            instr_in = vecs[i].instr; pc_in = 32'h100 + 32'(i * 4);
            step();
            chk($sformatf("vec%0d_imm", i), id_imm, vecs[i].imm);
            chk($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_illegal", i), 32'(id_illegal), 32'(vecs[i].illegal));
        end

        for (int n = 0; n < 400; n++) begin
            instr_in = rand_instr();
            pc_in    = {$urandom_range(0, 65535), 2'b00};
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_rd    = 5'($urandom_range(0, 31));
            wb_data  = $urandom;
            step();
        end

        // asynchronous reset mid-run, then a bubble and a regfile read
        @(negedge clk);
        wb_en = 1'b0; stall = 1'b0; flush = 1'b0; instr_in = 32'h00028313;
        reset = 1'b0;
        #1;
        exp_q = '0; flushed = 1'b0;
        check_all();
        chk("rst_valid", 32'(id_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1; instr_in = 32'h0;
        step();
        chk("rst_bubble_valid", 32'(id_valid), 32'h0);
        chk("rst_bubble_illegal", 32'(id_illegal), 32'h0);
        instr_in = 32'h00028313;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
